// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg -- shared definitions for the arbitrated sequential multiplier.
//
// Contents:
//   MUL_N_DEFAULT : default operand width in bits
//   state_t       : controller states (IDLE / BUSY / DONE)
//
// Build option (used by mul_seq_arb): MUL_SEQ_EARLY_EXIT_EN

package mul_seq_pkg;

    localparam int MUL_N_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : mul_seq_pkg

// File: rtl/mul_seq_arb_rr_arb2.sv
// rr_arb2 -- two-input round-robin arbiter.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   valid[1:0]  : request lines
//   accept      : the granted request was taken this cycle
//   grant[1:0]  : one-hot grant (all zero when nobody is valid)
//   grant_id    : index of the granted requester
//   ptr         : priority pointer (favoured requester on contention)
//
// A lone valid requester always wins. On contention the pointer decides.
// The pointer toggles on every accept and resets to requester 0.

module rr_arb2
    import mul_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant,
    output logic       grant_id,
    output logic       ptr
);

    always_comb begin
        grant_id = ptr;
        if (valid[0] && !valid[1]) begin
            grant_id = 1'b0;
        end else if (valid[1] && !valid[0]) begin
            grant_id = 1'b1;
        end
        grant = 2'b00;
        if (valid != 2'b00) begin
            grant = grant_id ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (accept) begin
            ptr <= ~ptr;
        end
    end

endmodule : rr_arb2

// File: rtl/mul_seq_arb.sv
// mul_seq_arb -- one shift-and-add multiplier shared by two requesters.
//
// Parameters:
//   N          : operand width (2..32), product is 2N bits
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req0_valid/a/b, req0_ready : requester 0 operand handshake
//   req1_valid/a/b, req1_ready : requester 1 operand handshake
//   rsp_valid/rsp_ready        : product handshake
//   rsp_id                     : requester that owns rsp_prod
//   rsp_prod                   : unsigned product a*b
//   busy                       : controller is not idle
//   dbg_state                  : current controller state (state_t encoding)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. reqX_ready is only ever high in IDLE for the granted, valid
// requester; rsp_valid is held with stable id/product until rsp_ready.
//
// Build option: define MUL_SEQ_EARLY_EXIT_EN to finish as soon as the
// remaining multiplier bits are all zero (at least one step, at most N).

module mul_seq_arb
    import mul_seq_pkg::*;
#(
    parameter int N = MUL_N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    input  logic [N-1:0]   req0_a,
    input  logic [N-1:0]   req0_b,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [N-1:0]   req1_a,
    input  logic [N-1:0]   req1_b,
    output logic           req1_ready,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [2*N-1:0] rsp_prod,
    output logic           busy,
    output logic [1:0]     dbg_state
);

    localparam int CW = $clog2(N);

    state_t           state;
    logic [N-1:0]     mcand;
    logic [N-1:0]     mplier;
    logic [2*N-1:0]   acc;
    logic [CW-1:0]    cnt;
    // Low during reset and for the first cycle after release, so no
    // request is offered ready while rst_n is asserted.
    logic             armed;

    logic [1:0]       grant;
    logic             grant_id;
    logic             arb_ptr;
    logic             accept;
    logic             in_idle;
    logic [2*N-1:0]   addend;
    logic             last_step;

    assign in_idle    = (state == ST_IDLE) && armed;
    assign req0_ready = in_idle && grant[0];
    assign req1_ready = in_idle && grant[1];
    assign accept     = req0_ready || req1_ready;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    ({req1_valid, req0_valid}),
        .accept   (accept),
        .grant    (grant),
        .grant_id (grant_id),
        .ptr      (arb_ptr)
    );

    always_comb begin
        addend = {{N{1'b0}}, mcand} << cnt;
`ifdef MUL_SEQ_EARLY_EXIT_EN
        // Stop once the multiplier left after this step's shift is zero.
        last_step = (cnt == CW'(N - 1)) || (mplier[N-1:1] == '0);
`else
        last_step = (cnt == CW'(N - 1));
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            armed     <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            rsp_id    <= 1'b0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        mcand  <= grant_id ? req1_a : req0_a;
                        mplier <= grant_id ? req1_b : req0_b;
                        rsp_id <= grant_id;
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mplier[0]) begin
                        acc <= acc + addend;
                    end
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last_step) begin
                        rsp_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_prod  = acc;
    assign dbg_state = state;

endmodule : mul_seq_arb

// File: tb/tb_mul_seq_arb.sv
// tb_mul_seq_arb -- directed bench for mul_seq_arb (N = 16).
//
// Drivers issue requests and push the hand-computed {id, product} plus the
// edge at which rsp_valid must first rise; an independent monitor pops and
// compares whenever the DUT presents or hands over a response.

module tb_mul_seq_arb;

    localparam int N = 16;

    logic           clk;
    logic           rst_n;
    logic           req0_valid;
    logic [N-1:0]   req0_a;
    logic [N-1:0]   req0_b;
    logic           req0_ready;
    logic           req1_valid;
    logic [N-1:0]   req1_a;
    logic [N-1:0]   req1_b;
    logic           req1_ready;
    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [2*N-1:0] rsp_prod;
    logic           busy;
    logic [1:0]     dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [2*N:0] exp_q[$];   // {id, product}
    int           lat_q[$];   // edge at which rsp_valid must first rise

    typedef struct {
        bit           id;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [31:0]  p;
    } vec_t;

    vec_t vecs[5] = '{
        '{1'b0, 16'h0094, 16'h0005, 32'h000002E4},
        '{1'b1, 16'h1234, 16'h0003, 32'h0000369C},
        '{1'b0, 16'h1234, 16'h0000, 32'h00000000},
        '{1'b1, 16'h8000, 16'h8000, 32'h40000000},
        '{1'b0, 16'hFFFF, 16'h0001, 32'h0000FFFF}
    };

    mul_seq_arb #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_prod   (rsp_prod),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no end expected end");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int steps(input logic [N-1:0] b);
        int s;
`ifdef MUL_SEQ_EARLY_EXIT_EN
        s = 1;
        for (int i = 0; i < N; i++) begin
            if (b[i]) s = i + 1;
        end
`else
        s = N;
`endif
        return s;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input bit id, input logic [N-1:0] a, input logic [N-1:0] b);
        if (id) begin
            req1_valid = 1'b1;
            req1_a     = a;
            req1_b     = b;
        end else begin
            req0_valid = 1'b1;
            req0_a     = a;
            req0_b     = b;
        end
    endtask

    // Called at a falling edge with the request already driven. Returns at
    // the falling edge after the accepting rising edge.
    task automatic wait_accept(input bit id, input logic [N-1:0] b, input logic [31:0] prod);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            #1;
            if (id ? req1_ready : req0_ready) begin
                @(negedge clk);
                if (id) req1_valid = 1'b0;
                else    req0_valid = 1'b0;
                exp_q.push_back({id, prod});
                lat_q.push_back(cyc + steps(b));
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) check("accept_timeout", {63'd0, id ? req1_ready : req0_ready}, 64'd1);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        @(negedge clk);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        logic         prev_valid;
        logic [2*N:0] e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_valid = 1'b0;
            end else begin
                if (rsp_valid && !prev_valid) begin
                    if (lat_q.size() == 0) check("unexpected_rsp_valid", rsp_valid, 0);
                    else                   check("latency_edge", cyc, lat_q.pop_front());
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_rsp", rsp_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_id", rsp_id, e[2*N]);
                        check("rsp_prod", rsp_prod, e[2*N-1:0]);
                    end
                end
                prev_valid = rsp_valid;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int t_acc;
        rst_n      = 1'b0;
        req0_valid = 1'b1;          // ready must stay low during reset
        req0_a     = '0;
        req0_b     = '0;
        req1_valid = 1'b0;
        req1_a     = '0;
        req1_b     = '0;
        rsp_ready  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_prod", rsp_prod, 0);
        check("rst_busy", busy, 0);
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_state", dbg_state, 0);
        req0_valid = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);

        // Contention right after reset: pointer favours requester 0.
        drive(1'b0, 16'd3, 16'd4);
        drive(1'b1, 16'hFFFF, 16'hFFFF);
        wait_accept(1'b0, 16'd4, 32'd12);
        wait_accept(1'b1, 16'hFFFF, 32'hFFFE0001);
        wait_drain();

        // Single-requester directed vectors.
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].id, vecs[i].a, vecs[i].b);
            wait_accept(vecs[i].id, vecs[i].b, vecs[i].p);
            wait_drain();
        end

        // Consumer stalls in DONE for 5 cycles.
        rsp_ready = 1'b0;
        drive(1'b1, 16'h00FF, 16'h0101);
        wait_accept(1'b1, 16'h0101, 32'h0000FFFF);
        for (int k = 0; k < 100 && !rsp_valid; k++) begin
            @(negedge clk);
            #2;
        end
        check("hold_reached_done", rsp_valid, 1);
        drive(1'b0, 16'h0001, 16'hFFFF);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #2;
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rsp_prod", rsp_prod, 32'h0000FFFF);
            check("hold_rsp_id", rsp_id, 1);
            check("hold_req0_ready", req0_ready, 0);
            check("hold_req1_ready", req1_ready, 0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        check("handshake_cycle_req0_ready", req0_ready, 0);
        @(negedge clk);
        wait_accept(1'b0, 16'hFFFF, 32'h0000FFFF);
        wait_drain();

        // Reset in the middle of BUSY, at step 7.
        drive(1'b0, 16'h1234, 16'h5678);
        wait_accept(1'b0, 16'h5678, 32'h0);
        t_acc = cyc;
        repeat (7) @(negedge clk);
        check("step7_busy", busy, 1);
        check("step7_cycle", cyc - t_acc, 7);
        rst_n = 1'b0;
        exp_q.delete();
        lat_q.delete();
        drive(1'b1, 16'd3, 16'd4);
        #1;
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_rsp_id", rsp_id, 0);
        check("midrst_rsp_prod", rsp_prod, 0);
        check("midrst_busy", busy, 0);
        check("midrst_req0_ready", req0_ready, 0);
        check("midrst_req1_ready", req1_ready, 0);
        req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            #2;
            check("post_rst_no_rsp", rsp_valid, 0);
        end
        @(negedge clk);
        drive(1'b1, 16'd3, 16'd4);
        wait_accept(1'b1, 16'd4, 32'd12);
        wait_drain();

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mul_seq_arb

// File: doc/mul_seq_arb.md
MUL_SEQ_ARB -- requirements
Module: mul_seq_arb

Interface
REQ-001 SHALL have parameter N, default 16, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports req0_valid/req1_valid, input, 1 each, requester has operands.
REQ-005 SHALL have ports req0_a/req0_b/req1_a/req1_b, input, N each, unsigned operands.
REQ-006 SHALL have ports req0_ready/req1_ready, output, 1 each, operands accepted this cycle when high with valid.
REQ-007 SHALL have port rsp_valid, output, 1, product available.
REQ-008 SHALL have port rsp_ready, input, 1, consumer takes product.
REQ-009 SHALL have port rsp_id, output, 1, index of the requester that owns rsp_prod.
REQ-010 SHALL have port rsp_prod, output, 2N, unsigned product a*b.
REQ-011 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-012 SHALL share one N-bit shift-and-add datapath between two requesters; one operation in flight at a time.
REQ-013 SHALL implement states IDLE, BUSY, DONE.
REQ-014 IDLE: SHALL drive reqX_ready high for the granted requester only, and only while that requester is valid. Ready for the other requester SHALL stay low.
REQ-015 Arbitration SHALL be round-robin:
  - a priority pointer names the favoured requester and resets to 0;
  - if only one requester is valid, that requester is granted;
  - if both are valid, the pointer's requester is granted;
  - the pointer flips to the other requester on every accept.
REQ-016 On accept (valid&ready at edge T), SHALL:
  - latch the multiplicand (a) and multiplier (b);
  - latch rsp_id to the granted index;
  - clear the 2N-bit accumulator and step counter;
  - enter BUSY.
REQ-017 BUSY: at each edge, SHALL first add the multiplicand, shifted left by the step count, to the accumulator when multiplier bit0 = 1. It SHALL then shift the multiplier right by 1 and increment the counter.
REQ-018 Without early exit, SHALL perform exactly N steps at edges T+1..T+N and enter DONE at edge T+N.
REQ-019 DONE: SHALL hold rsp_valid=1 and keep rsp_prod and rsp_id stable until rsp_ready=1. It SHALL return to IDLE at that edge.
REQ-020 SHALL not accept a new request in the cycle the response handshake completes; acceptance resumes in the following IDLE cycle.
REQ-021 Arithmetic SHALL be unsigned and exact. The accumulator is 2N bits, and the sum cannot overflow for N-bit operands.
REQ-022 Request inputs SHALL be ignored outside IDLE, and requests withdrawn before acceptance SHALL have no effect.

Reset
REQ-023 SHALL, on rst_n low at any time including mid-BUSY or DONE, abandon the operation and reset all of the following:
  - state to IDLE and pointer to 0;
  - rsp_valid, rsp_id, rsp_prod, busy and both reqX_ready to 0;
  - accumulator, counter and operand registers to 0.
REQ-024 SHALL produce no response for an abandoned operation after reset release.

Configuration
REQ-025 With macro MUL_SEQ_EARLY_EXIT_EN defined, BUSY SHALL enter DONE at the first edge where the shifted multiplier becomes zero, capped at N steps. An operation with b=0 therefore enters DONE at T+1.
REQ-026 Without MUL_SEQ_EARLY_EXIT_EN, latency SHALL be fixed per REQ-018 regardless of operand values.

Structure
REQ-027 SHALL take the state enumeration (IDLE/BUSY/DONE) and the default width constant from shared package mul_seq_pkg.
REQ-028 SHALL contain one sub-module, rr_arb2: two-input round-robin arbiter with pointer update on accept; all else inline.

Verification
REQ-029 N=16, req0 a=0x0094, b=0x0005 alone → rsp_id=0, rsp_prod=0x000002E4, rsp_valid first high after edge T+16 (no macro).
REQ-030 Both valid after reset, req0 a=3 b=4, req1 a=0xFFFF b=0xFFFF, rsp_ready=1 → first rsp_id=0 prod=12, then rsp_id=1 prod=0xFFFE0001.
REQ-031 rsp_ready held low 5 cycles in DONE → rsp_valid, rsp_prod, rsp_id stable all 5 cycles; no reqX_ready during hold.
REQ-032 rst_n pulsed low at BUSY step 7 → all outputs 0 immediately; no rsp_valid afterwards until a new accept.
REQ-033 MUL_SEQ_EARLY_EXIT_EN, a=0x1234 b=0 → DONE at T+1, prod=0. Then b=0x0003 → DONE at T+2, prod=0x369C. Without macro, both take 16 steps.
